// File: rtl/mem_port_arbiter_if.sv
// Request/completion bundle between the three requesters, the arbiter and the
// byte-serial memory controller. The arbiter takes the slave view; the
// environment (requesters plus controller) takes the master view.
interface mem_port_arbiter_if #(
  parameter int unsigned LSB_TYPE_WIDTH = 4
);
  logic                      rdy_in;
  logic                      flush;
  logic                      io_buffer_full;

  logic                      if_en;
  logic [31:0]               if_addr;
  logic                      if_rdy;

  logic                      lsb_en;
  logic [31:0]               lsb_addr;
  logic [LSB_TYPE_WIDTH-1:0] lsb_type;
  logic [31:0]               lsb_wdata;
  logic                      lsb_rdy;

  logic                      pf_en;
  logic [31:0]               pf_addr;
  logic                      pf_rdy;

  logic [31:0]               rd_data;

  logic                      mc_en;
  logic                      mc_is_lsb;
  logic [31:0]               mc_addr;
  logic [LSB_TYPE_WIDTH-1:0] mc_type;
  logic [31:0]               mc_wdata;
  logic                      mc_rdy;
  logic [31:0]               mc_rdata;

  logic [1:0]                grant_id;
  logic [3:0]                starve_cnt;

  modport slave (
    input  rdy_in, flush, io_buffer_full,
    input  if_en, if_addr,
    input  lsb_en, lsb_addr, lsb_type, lsb_wdata,
    input  pf_en, pf_addr,
    input  mc_rdy, mc_rdata,
    output if_rdy, lsb_rdy, pf_rdy, rd_data,
    output mc_en, mc_is_lsb, mc_addr, mc_type, mc_wdata,
    output grant_id, starve_cnt
  );

  modport master (
    output rdy_in, flush, io_buffer_full,
    output if_en, if_addr,
    output lsb_en, lsb_addr, lsb_type, lsb_wdata,
    output pf_en, pf_addr,
    output mc_rdy, mc_rdata,
    input  if_rdy, lsb_rdy, pf_rdy, rd_data,
    input  mc_en, mc_is_lsb, mc_addr, mc_type, mc_wdata,
    input  grant_id, starve_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the memory controller's single request port between instruction
// fetch, the load/store buffer and the prefetcher. Fixed priority
// LSB > IF > PF with an IF anti-starvation override, non-preemptive
// transactions, and one idle GAP cycle after every completion.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned LSB_TYPE_WIDTH = 4
) (
  input logic               clk_in,
  input logic               rst_in,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_IF   = 2'b01,
    GNT_LSB  = 2'b10,
    GNT_PF   = 2'b11
  } grant_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t                    state_q, state_d;
  grant_t                    grant_q, grant_d;
  grant_t                    winner;
  logic                      mc_en_q, mc_en_d;
  logic                      mc_is_lsb_q, mc_is_lsb_d;
  logic [31:0]               mc_addr_q, mc_addr_d;
  logic [LSB_TYPE_WIDTH-1:0] mc_type_q, mc_type_d;
  logic [31:0]               mc_wdata_q, mc_wdata_d;
  logic [3:0]                starve_q, starve_d;

  logic if_ok, lsb_ok, pf_ok, flush_eff, done;

  assign if_ok     = bus.if_en;
  assign lsb_ok    = bus.lsb_en && !bus.io_buffer_full;
  assign pf_ok     = bus.pf_en && !bus.if_en && !bus.lsb_en;
  assign flush_eff = bus.flush && bus.rdy_in;

  // Arbitration: LSB wins unless IF has waited through LIMIT LSB grants.
  always_comb begin
    if (lsb_ok && !(if_ok && starve_q == LIMIT)) winner = GNT_LSB;
    else if (if_ok)                              winner = GNT_IF;
    else if (pf_ok)                              winner = GNT_PF;
    else                                         winner = GNT_NONE;
  end

  // Next-state and next-output logic; everything holds while rdy_in is low.
  always_comb begin
    // NOTE: every target gets a hold value first so no path can infer a latch.
    state_d     = state_q;
    grant_d     = grant_q;
    mc_en_d     = mc_en_q;
    mc_is_lsb_d = mc_is_lsb_q;
    mc_addr_d   = mc_addr_q;
    mc_type_d   = mc_type_q;
    mc_wdata_d  = mc_wdata_q;
    starve_d    = starve_q;

    if (bus.rdy_in) begin
      if (bus.flush) begin
        state_d  = IDLE;
        mc_en_d  = 1'b0;
        grant_d  = GNT_NONE;
        starve_d = '0;
      end else begin
        case (state_q)
          IDLE: begin
            mc_en_d = 1'b0;
            if (winner != GNT_NONE) begin
              state_d     = BUSY;
              mc_en_d     = 1'b1;
              grant_d     = winner;
              mc_is_lsb_d = (winner == GNT_LSB);
              mc_type_d   = '0;
              mc_wdata_d  = '0;
              case (winner)
                GNT_LSB: begin
                  mc_addr_d  = bus.lsb_addr;
                  mc_type_d  = bus.lsb_type;
                  mc_wdata_d = bus.lsb_wdata;
                end
                GNT_IF:  mc_addr_d = bus.if_addr;
                default: mc_addr_d = bus.pf_addr;
              endcase
              // Only an LSB win over a waiting IF counts toward starvation.
              if (winner == GNT_LSB && bus.if_en)
                starve_d = (starve_q == LIMIT) ? LIMIT : starve_q + 4'd1;
              else
                starve_d = '0;
            end
          end
          BUSY: begin
            if (bus.mc_rdy) begin
              state_d = GAP;
              mc_en_d = 1'b0;
              grant_d = GNT_NONE;
            end
          end
          GAP:     state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State and registered controller-facing outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    if (!rst_in) begin
      state_q     <= IDLE;
      grant_q     <= GNT_NONE;
      mc_en_q     <= 1'b0;
      mc_is_lsb_q <= 1'b0;
      mc_addr_q   <= '0;
      mc_type_q   <= '0;
      mc_wdata_q  <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mc_en_q     <= mc_en_d;
      mc_is_lsb_q <= mc_is_lsb_d;
      mc_addr_q   <= mc_addr_d;
      mc_type_q   <= mc_type_d;
      mc_wdata_q  <= mc_wdata_d;
      starve_q    <= starve_d;
    end
  end

  // Completion pulses are combinational so the requester sees rd_data in the mc_rdy cycle.
  assign done        = bus.mc_rdy && (state_q == BUSY) && !flush_eff;
  assign bus.if_rdy  = done && (grant_q == GNT_IF);
  assign bus.lsb_rdy = done && (grant_q == GNT_LSB);
  assign bus.pf_rdy  = done && (grant_q == GNT_PF);
  assign bus.rd_data = bus.mc_rdata;

  assign bus.mc_en      = mc_en_q;
  assign bus.mc_is_lsb  = mc_is_lsb_q;
  assign bus.mc_addr    = mc_addr_q;
  assign bus.mc_type    = mc_type_q;
  assign bus.mc_wdata   = mc_wdata_q;
  assign bus.grant_id   = grant_q;
  assign bus.starve_cnt = starve_q;

endmodule
